// File: rtl/spi_pkt_master.sv
// spi_pkt_master: host-side SPI mode-0 master. Sends a PKT_BYTES packet MSB first,
// one CS_n frame per byte, and collects the slave's MISO bytes into rx_data_o.
module spi_pkt_master #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned PKT_BYTES = 3,
   parameter int unsigned GAP_CYC   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [8*PKT_BYTES-1:0] tx_data_i,
   input  logic                   miso_i,
   output logic                   sck_o,
   output logic                   cs_n_o,
   output logic                   mosi_o,
   output logic                   busy_o,
   output logic                   byte_done_o,
   output logic [7:0]             rx_byte_o,
   output logic                   done_o,
   output logic [8*PKT_BYTES-1:0] rx_data_o
);
   localparam int unsigned PW   = 8 * PKT_BYTES;
   localparam int unsigned CMAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam int unsigned BW   = $clog2(PKT_BYTES + 1);

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, GAP, FIN} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      tgl_q;
   logic [BW-1:0]   byte_q;
   logic [PW-1:0]   tx_sr_q;
   logic [7:0]      rx_sr_q;
   logic            sck_q, cs_n_q, mosi_q, busy_q, byte_done_q, done_q;
   logic [7:0]      rx_byte_q;
   logic [PW-1:0]   rx_data_q;
   logic            div_end, gap_end;

   // Shared cycle counter: next value and end-of-interval flags.
   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      div_end = (cnt_q == CW'(CLK_DIV - 1));
      gap_end = (cnt_q == CW'(GAP_CYC - 1));
   end

   // Packet sequencer with registered SPI pins and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tgl_q       <= '0;
         byte_q      <= '0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         sck_q       <= 1'b0;
         cs_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         busy_q      <= 1'b0;
         byte_done_q <= 1'b0;
         done_q      <= 1'b0;
         rx_byte_q   <= '0;
         rx_data_q   <= '0;
      end else begin
         byte_done_q <= 1'b0;
         done_q      <= 1'b0;
         if (abort_i && state_q != IDLE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgl_q   <= '0;
            byte_q  <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_i && !abort_i) begin
                     tx_sr_q <= tx_data_i;
                     byte_q  <= '0;
                     cnt_q   <= '0;
                     tgl_q   <= '0;
                     state_q <= LOAD;
                  end
               end
               // One cycle between sampling start and driving the bus, so busy and
               // CS_n appear the cycle after the start edge.
               LOAD: begin
                  busy_q  <= 1'b1;
                  cs_n_q  <= 1'b0;
                  mosi_q  <= tx_sr_q[PW-1];
                  state_q <= SETUP;
               end
               SETUP: begin
                  if (div_end) begin
                     cnt_q   <= '0;
                     state_q <= SHIFT;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               SHIFT: begin
                  if (div_end) begin
                     cnt_q <= '0;
                     sck_q <= ~sck_q;
                     tgl_q <= tgl_q + 4'd1;
                     if (!sck_q) begin
                        rx_sr_q <= {rx_sr_q[6:0], miso_i};
                     end else begin
                        // Shift on every fall; the 16th leaves the next byte's MSB on top.
                        tx_sr_q <= tx_sr_q << 1;
                        if (tgl_q != 4'd15) mosi_q <= tx_sr_q[PW-2];
                        else                state_q <= HOLD;
                     end
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               HOLD: begin
                  if (div_end) begin
                     cnt_q       <= '0;
                     cs_n_q      <= 1'b1;
                     byte_done_q <= 1'b1;
                     rx_byte_q   <= rx_sr_q;
                     for (int unsigned i = 0; i < PKT_BYTES; i++) begin
                        if (byte_q == BW'(i)) rx_data_q[8*(PKT_BYTES-1-i) +: 8] <= rx_sr_q;
                     end
                     byte_q  <= byte_q + BW'(1);
                     state_q <= GAP;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               GAP: begin
                  if (gap_end) begin
                     cnt_q <= '0;
                     if (byte_q == BW'(PKT_BYTES)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        mosi_q  <= 1'b0;
                        state_q <= FIN;
                     end else begin
                        cs_n_q  <= 1'b0;
                        mosi_q  <= tx_sr_q[PW-1];
                        state_q <= SETUP;
                     end
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               FIN: state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign sck_o       = sck_q;
   assign cs_n_o      = cs_n_q;
   assign mosi_o      = mosi_q;
   assign busy_o      = busy_q;
   assign byte_done_o = byte_done_q;
   assign rx_byte_o   = rx_byte_q;
   assign done_o      = done_q;
   assign rx_data_o   = rx_data_q;

endmodule

// File: tb/tb_spi_pkt_master.sv
// Bench for spi_pkt_master: random packets against an SPI mode-0 bus decoder and
// slave model, plus fixed abort, reset and start-filtering scenarios.
`timescale 1ns/1ps
module tb_spi_pkt_master;
   localparam int DIV_A = 4, PKT_A = 3, GAP_A = 8;
   localparam int LAT_A = 1 + PKT_A * (18 * DIV_A + GAP_A);
   localparam int DIV_B = 2, GAP_B = 8;
   localparam int LAT_B = 1 + (18 * DIV_B + GAP_B);

   logic clk = 1'b0, rst = 1'b0;
   logic start = 1'b0, abort = 1'b0;
   logic [23:0] tx_data = '0;
   logic miso;
   logic sck, cs_n, mosi, busy, byte_done, done;
   logic [7:0] rx_byte;
   logic [23:0] rx_data;

   logic start6 = 1'b0;
   logic [7:0] tx6 = '0;
   logic sck6, cs6, mosi6, busy6, bd6, done6;
   logic [7:0] rxb6, rxd6;

   int checks = 0, errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_pkt_master #(.CLK_DIV(DIV_A), .PKT_BYTES(PKT_A), .GAP_CYC(GAP_A)) dut (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .tx_data_i(tx_data),
      .miso_i(miso), .sck_o(sck), .cs_n_o(cs_n), .mosi_o(mosi), .busy_o(busy),
      .byte_done_o(byte_done), .rx_byte_o(rx_byte), .done_o(done), .rx_data_o(rx_data));

   spi_pkt_master #(.CLK_DIV(DIV_B), .PKT_BYTES(1), .GAP_CYC(GAP_B)) dut6 (
      .clk(clk), .rst(rst), .start_i(start6), .abort_i(1'b0), .tx_data_i(tx6),
      .miso_i(mosi6), .sck_o(sck6), .cs_n_o(cs6), .mosi_o(mosi6), .busy_o(busy6),
      .byte_done_o(bd6), .rx_byte_o(rxb6), .done_o(done6), .rx_data_o(rxd6));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus decoder / slave model state
   bit          loop = 1'b0;
   logic        miso_s = 1'b0;
   logic [7:0]  slv_b [3];
   logic [23:0] tx_exp = '0;
   logic [23:0] rx_model = '0;
   int          mon_byte = 0, bd_cnt = 0, lo_cnt = 0, hi_cnt = 1000, nbits = 0;
   bit          skip_cs = 1'b0;
   logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
   logic [7:0]  mon_sh = '0, slv_sh = '0;

   assign miso = loop ? mosi : miso_s;

   always @(negedge clk) begin
      if (!rst) begin
         prev_cs = 1'b1; prev_sck = 1'b0; prev_mosi = 1'b0; miso_s = 1'b0; hi_cnt = 1000;
      end else begin
         if (byte_done) begin
            check_eq("bd_at_cs_rise", {prev_cs, cs_n}, 2'b01);
            if (bd_cnt < PKT_A) check_eq("rx_byte", rx_byte, slv_b[bd_cnt]);
            bd_cnt++;
         end
         if (!prev_cs && cs_n) begin
            if (!skip_cs && mon_byte < PKT_A) begin
               check_eq("cs_low_len", lo_cnt, 18 * DIV_A);
               check_eq("mosi_bits", nbits, 8);
               check_eq("mosi_byte", mon_sh, tx_exp[23-8*mon_byte -: 8]);
            end
            mon_byte++;
            hi_cnt = 0;
         end
         if (prev_cs && !cs_n) begin
            check_eq("cs_gap_min", hi_cnt >= GAP_A, 1);
            lo_cnt = 0; nbits = 0;
            slv_sh = (mon_byte < PKT_A) ? slv_b[mon_byte] : 8'h00;
            miso_s = slv_sh[7];
         end
         if (!cs_n) begin
            if (!prev_sck && sck) begin
               check_eq("mosi_stable", mosi, prev_mosi);
               mon_sh = {mon_sh[6:0], mosi};
               nbits++;
            end
            if (prev_sck && !sck) begin
               slv_sh = slv_sh << 1;
               miso_s = slv_sh[7];
            end
            lo_cnt++;
         end else begin
            hi_cnt++;
         end
         prev_cs = cs_n; prev_sck = sck; prev_mosi = mosi;
      end
   end

   // Bus decoder for the small instance
   logic p6_cs = 1'b1, p6_sck = 1'b0;
   int lo6 = 0, n6 = 0;
   logic [7:0] sh6 = '0, exp6 = '0;

   always @(negedge clk) begin
      if (!rst) begin
         p6_cs = 1'b1; p6_sck = 1'b0;
      end else begin
         if (!p6_cs && cs6) begin
            check_eq("t6_cs_len", lo6, 18 * DIV_B);
            check_eq("t6_bits", n6, 8);
            check_eq("t6_mosi", sh6, exp6);
         end
         if (p6_cs && !cs6) begin lo6 = 0; n6 = 0; end
         if (!cs6) begin
            if (!p6_sck && sck6) begin sh6 = {sh6[6:0], mosi6}; n6++; end
            lo6++;
         end
         p6_cs = cs6; p6_sck = sck6;
      end
   end

   task automatic kick(input logic [23:0] tx, input logic [23:0] slv, input bit lb, output int s);
      loop = lb;
      tx_exp = tx;
      for (int i = 0; i < 3; i++) slv_b[i] = lb ? tx[23-8*i -: 8] : slv[23-8*i -: 8];
      mon_byte = 0; bd_cnt = 0; skip_cs = 1'b0;
      @(negedge clk); start = 1'b1; tx_data = tx;
      @(negedge clk); start = 1'b0; s = cyc;
   endtask

   task automatic run_pkt(input logic [23:0] tx, input logic [23:0] slv, input bit lb, input bit poke);
      int s; bit got; bit stray;
      logic [23:0] exp_rx;
      exp_rx = lb ? tx : slv;
      kick(tx, slv, lb, s);
      check_eq("load_busy", busy, 0);
      check_eq("load_cs", cs_n, 1);
      @(negedge clk);
      check_eq("busy_on", busy, 1);
      check_eq("cs_low", cs_n, 0);
      check_eq("mosi_msb", mosi, tx[23]);
      got = 1'b0;
      for (int i = 0; i < LAT_A + 50 && !got; i++) begin
         start = poke && (cyc - s == 9);
         if (poke && (cyc - s == 9)) tx_data = ~tx;
         @(negedge clk);
         got = done;
      end
      start = 1'b0;
      check_eq("done_seen", got, 1);
      check_eq("done_latency", cyc - s, LAT_A);
      check_eq("busy_at_done", busy, 0);
      check_eq("rx_data", rx_data, exp_rx);
      check_eq("byte_done_cnt", bd_cnt, PKT_A);
      rx_model = exp_rx;
      start = poke;
      @(negedge clk); start = 1'b0;
      check_eq("done_pulse_len", done, 0);
      stray = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (busy || !cs_n || done) stray = 1'b1;
      end
      check_eq("no_restart", stray, 0);
      check_eq("rx_data_hold", rx_data, exp_rx);
   endtask

   task automatic abort_pkt(input logic [23:0] tx, input logic [23:0] slv);
      int s; bit stray;
      kick(tx, slv, 1'b0, s);
      repeat (99) @(negedge clk);
      check_eq("busy_pre_abort", busy, 1);
      abort = 1'b1; skip_cs = 1'b1;
      @(negedge clk); abort = 1'b0;
      check_eq("abort_cs", cs_n, 1);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_sck", sck, 0);
      check_eq("abort_mosi", mosi, 0);
      rx_model = {slv[23:16], rx_model[15:0]};
      stray = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done || byte_done || !cs_n) stray = 1'b1;
      end
      check_eq("abort_quiet", stray, 0);
      check_eq("abort_rx_data", rx_data, rx_model);
      check_eq("abort_bd_cnt", bd_cnt, 1);
   endtask

   task automatic reset_mid(input logic [23:0] tx);
      int s;
      kick(tx, ~tx, 1'b0, s);
      repeat (27) @(negedge clk);
      check_eq("busy_pre_rst", busy, 1);
      check_eq("sck_pre_rst", sck, 1);
      skip_cs = 1'b1;
      #2 rst = 1'b0;
      #1;
      check_eq("rst_sck", sck, 0);
      check_eq("rst_cs", cs_n, 1);
      check_eq("rst_rx_data", rx_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_mosi", mosi, 0);
      rx_model = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic run6(input logic [7:0] v);
      int s; bit got;
      tx6 = v; exp6 = v;
      @(negedge clk); start6 = 1'b1;
      @(negedge clk); start6 = 1'b0; s = cyc;
      got = 1'b0;
      for (int i = 0; i < LAT_B + 30 && !got; i++) begin
         @(negedge clk);
         got = done6;
      end
      check_eq("t6_done_seen", got, 1);
      check_eq("t6_latency", cyc - s, LAT_B);
      check_eq("t6_rx_data", rxd6, v);
      check_eq("t6_busy", busy6, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bit stray;
      repeat (3) @(negedge clk);
      check_eq("reset_pins", {sck, cs_n, mosi}, 3'b010);
      check_eq("reset_status", {busy, byte_done, done}, 3'b000);
      check_eq("reset_rx_byte", rx_byte, 0);
      check_eq("reset_rx_data", rx_data, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      run_pkt(24'hA53C0F, 24'h000000, 1'b1, 1'b0);
      run_pkt(24'($urandom), 24'h8142FF, 1'b0, 1'b0);
      run_pkt(24'($urandom), 24'($urandom), 1'b0, 1'b1);
      for (int n = 0; n < 4; n++)
         run_pkt(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)), 1'b0);

      abort_pkt(24'($urandom), 24'hC35A96);
      run_pkt(24'($urandom), 24'($urandom), 1'b0, 1'b0);

      @(negedge clk); start = 1'b1; abort = 1'b1; tx_data = 24'($urandom);
      @(negedge clk); start = 1'b0; abort = 1'b0;
      stray = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (busy || !cs_n) stray = 1'b1;
      end
      check_eq("abort_beats_start", stray, 0);

      reset_mid(24'($urandom));
      run_pkt(24'($urandom), 24'($urandom), 1'b0, 1'b0);

      run6(8'h00);
      run6(8'hFF);
      run6(8'($urandom));
      run6(8'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
